// File: rtl/audio_pkg.sv
// Shared audio constants, increment formula and sequencer state encoding.
// The increment formula must stay identical to the oscillator's.
package audio_pkg;

    localparam int unsigned INC_WIDTH       = 21;
    // 8 MHz / SAMPLECLOCK_DIV / 32 gives SAMPLEFREQ.
    localparam int unsigned SAMPLECLOCK_DIV = 8;
    localparam int unsigned SAMPLEFREQ      = 31250;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

    // Phase increment for a note frequency given in milli-Hz.
    function automatic logic [INC_WIDTH-1:0] calc_increment(input int unsigned freq_mhz);
        logic [63:0] num;
        num = 64'(freq_mhz) << INC_WIDTH;
        return INC_WIDTH'(num / (64'(SAMPLEFREQ) * 64'd1000));
    endfunction

endpackage

// File: rtl/step_ram.sv
// Pattern storage: synchronous write, combinational read, no reset.
// The reader registers the read data, so a same-clk write is never seen early.
module step_ram #(
    parameter int unsigned STEPS     = 16,
    parameter int unsigned INC_WIDTH = 21,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [INC_WIDTH-1:0]       wr_inc,
    input  logic [LEN_WIDTH-1:0]       wr_len,
    input  logic [$clog2(STEPS)-1:0]   rd_addr,
    output logic [INC_WIDTH-1:0]       rd_inc,
    output logic [LEN_WIDTH-1:0]       rd_len
);

    logic [INC_WIDTH-1:0] inc_mem_q [STEPS];
    logic [LEN_WIDTH-1:0] len_mem_q [STEPS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inc_mem_q[wr_addr] <= wr_inc;
            len_mem_q[wr_addr] <= wr_len;
        end
    end

    assign rd_inc = inc_mem_q[rd_addr];
    assign rd_len = len_mem_q[rd_addr];

endmodule

// File: rtl/gate_sequencer.sv
// Looping step sequencer driving oscillator increment and AR gate,
// advancing on synchronized sample_clock rising edges.
module gate_sequencer #(
    parameter int unsigned STEPS       = 16,
    parameter int unsigned INC_WIDTH   = audio_pkg::INC_WIDTH,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned TEMPO_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_clock,
    input  logic                       run,
    input  logic [TEMPO_WIDTH-1:0]     tempo,
    input  logic [$clog2(STEPS):0]     num_steps,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [INC_WIDTH-1:0]       wr_increment,
    input  logic [LEN_WIDTH-1:0]       wr_gate_len,
    output logic [INC_WIDTH-1:0]       increment,
    output logic                       gate,
    output logic [$clog2(STEPS)-1:0]   step,
    output logic                       step_strobe
);

    import audio_pkg::*;

    localparam int unsigned STEP_W = $clog2(STEPS);
    localparam int unsigned NUM_W  = STEP_W + 1;
    localparam int unsigned LEN_XW = LEN_WIDTH + 1;
    localparam int unsigned TMP_XW = TEMPO_WIDTH + 1;

    seq_state_e              state_q, state_d;
    logic [2:0]              sync_q;
    logic [INC_WIDTH-1:0]    inc_q, inc_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    gate_q, gate_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    strobe_q, strobe_d;
    logic [TEMPO_WIDTH-1:0]  step_cnt_q, step_cnt_d;
    logic [LEN_WIDTH-1:0]    gate_cnt_q, gate_cnt_d;

    logic                    tick;
    logic                    load;
    logic [TEMPO_WIDTH-1:0]  tempo_eff;
    logic [NUM_W-1:0]        num_eff;
    logic [NUM_W-1:0]        step_inc;
    logic [STEP_W-1:0]       next_step;
    logic                    gate_hit;
    logic                    step_hit;
    logic [STEP_W-1:0]       rd_addr;
    logic [INC_WIDTH-1:0]    rd_inc;
    logic [LEN_WIDTH-1:0]    rd_len;

    // Two synchronizer stages plus one history bit for the rising-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sample_clock};
        end
    end

    assign tick = sync_q[1] & ~sync_q[2];

    assign tempo_eff = (tempo == '0) ? TEMPO_WIDTH'(1) : tempo;
    assign num_eff   = (num_steps == '0)           ? NUM_W'(1) :
                       (num_steps > NUM_W'(STEPS)) ? NUM_W'(STEPS) : num_steps;

    // >= so that shrinking num_steps below the current step still wraps.
    assign step_inc  = NUM_W'(step_q) + NUM_W'(1);
    assign next_step = (step_inc >= num_eff) ? '0 : STEP_W'(step_inc);

    assign gate_hit = (LEN_XW'(gate_cnt_q) + LEN_XW'(1)) == LEN_XW'(len_q);
    assign step_hit = (TMP_XW'(step_cnt_q) + TMP_XW'(1)) == TMP_XW'(tempo_eff);

    assign rd_addr = (state_q == ST_PLAY) ? next_step : '0;

    step_ram #(
        .STEPS     (STEPS),
        .INC_WIDTH (INC_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_step_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_inc  (wr_increment),
        .wr_len  (wr_gate_len),
        .rd_addr (rd_addr),
        .rd_inc  (rd_inc),
        .rd_len  (rd_len)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inc_q      <= '0;
            len_q      <= '0;
            gate_q     <= 1'b0;
            step_q     <= '0;
            strobe_q   <= 1'b0;
            step_cnt_q <= '0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inc_q      <= inc_d;
            len_q      <= len_d;
            gate_q     <= gate_d;
            step_q     <= step_d;
            strobe_q   <= strobe_d;
            step_cnt_q <= step_cnt_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inc_d      = inc_q;
        len_d      = len_q;
        gate_d     = gate_q;
        step_d     = step_q;
        strobe_d   = 1'b0;
        step_cnt_d = step_cnt_q;
        gate_cnt_d = gate_cnt_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_d = 1'b0;
                step_d = '0;
                if (run && tick) begin
                    load    = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!run) begin
                    gate_d     = 1'b0;
                    step_d     = '0;
                    step_cnt_d = '0;
                    gate_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (tick) begin
                    step_cnt_d = step_cnt_q + TEMPO_WIDTH'(1);
                    gate_cnt_d = (&gate_cnt_q) ? gate_cnt_q : gate_cnt_q + LEN_WIDTH'(1);
                    if (gate_hit) begin
                        gate_d = 1'b0;
                    end
                    if (step_hit) begin
                        step_d = next_step;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load overrides the gate drop, which is what makes legato seamless.
        if (load) begin
            inc_d      = rd_inc;
            len_d      = rd_len;
            gate_d     = (rd_len != '0);
            step_cnt_d = '0;
            gate_cnt_d = '0;
            strobe_d   = 1'b1;
        end
    end

    assign increment   = inc_q;
    assign gate        = gate_q;
    assign step        = step_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: constant vector table, hand-built corner sequences,
// and randomized play checked against a tick-level note-timeline model.
module tb_gate_sequencer;

    import audio_pkg::*;

    localparam int unsigned STEPS       = 16;
    localparam int unsigned LEN_WIDTH   = 16;
    localparam int unsigned TEMPO_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sample_clock;
    logic                   run;
    logic [TEMPO_WIDTH-1:0] tempo;
    logic [4:0]             num_steps;
    logic                   wr_en;
    logic [3:0]             wr_addr;
    logic [INC_WIDTH-1:0]   wr_increment;
    logic [LEN_WIDTH-1:0]   wr_gate_len;
    logic [INC_WIDTH-1:0]   increment;
    logic                   gate;
    logic [3:0]             step;
    logic                   step_strobe;

    gate_sequencer #(
        .STEPS       (STEPS),
        .INC_WIDTH   (INC_WIDTH),
        .LEN_WIDTH   (LEN_WIDTH),
        .TEMPO_WIDTH (TEMPO_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_clock (sample_clock),
        .run          (run),
        .tempo        (tempo),
        .num_steps    (num_steps),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_increment (wr_increment),
        .wr_gate_len  (wr_gate_len),
        .increment    (increment),
        .gate         (gate),
        .step         (step),
        .step_strobe  (step_strobe)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Edge monitors, sampled mid-cycle.
    int unsigned strobe_cnt = 0;
    int unsigned gate_falls = 0;
    logic        gate_prev  = 1'b0;
    always @(negedge clk) begin
        if (step_strobe === 1'b1) strobe_cnt++;
        if (gate_prev === 1'b1 && gate === 1'b0) gate_falls++;
        gate_prev = gate;
    end

    // Reference model: a note timeline measured in whole ticks.
    logic [INC_WIDTH-1:0] m_ram_inc [STEPS];
    logic [LEN_WIDTH-1:0] m_ram_len [STEPS];
    bit                   m_play   = 1'b0;
    int unsigned          m_step   = 0;
    int unsigned          m_t      = 0;
    int unsigned          m_len    = 0;
    logic [INC_WIDTH-1:0] m_inc    = '0;
    int unsigned          m_strobe = 0;

    logic [INC_WIDTH-1:0] note_inc [4];

    typedef struct {
        int unsigned ticks;
        int unsigned exp_step;
        bit          exp_gate;
        int unsigned exp_strobes;
        int unsigned note;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned tempo_eff();
        return (tempo == 0) ? 1 : int'(tempo);
    endfunction

    function automatic int unsigned num_eff();
        if (num_steps == 0) return 1;
        if (num_steps > STEPS) return STEPS;
        return int'(num_steps);
    endfunction

    task automatic model_load(input int unsigned s);
        m_step   = s;
        m_t      = 0;
        m_inc    = m_ram_inc[s];
        m_len    = m_ram_len[s];
        m_strobe = 1;
    endtask

    task automatic model_tick();
        m_strobe = 0;
        if (!m_play) begin
            if (run) begin
                m_play = 1'b1;
                model_load(0);
            end
        end else begin
            m_t++;
            if (m_t == tempo_eff()) begin
                model_load((m_step + 1 >= num_eff()) ? 0 : m_step + 1);
            end
        end
    endtask

    // One sample_clock period; optional RAM write lands on the clk that acts on the tick.
    task automatic do_tick(input bit w, input int unsigned a,
                           input logic [INC_WIDTH-1:0] inc, input logic [LEN_WIDTH-1:0] len);
        int unsigned s0;
        s0 = strobe_cnt;
        @(posedge clk); #1 sample_clock = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        if (w) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_increment = inc; wr_gate_len = len;
        end
        @(posedge clk); #1 wr_en = 1'b0;
        sample_clock = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_tick();
        if (w) begin
            m_ram_inc[a] = inc;
            m_ram_len[a] = len;
        end
        chk("model_step", 64'(step), 64'(m_step));
        chk("model_gate", 64'(gate), 64'(m_play && (m_t < m_len)));
        chk("model_increment", 64'(increment), 64'(m_inc));
        chk("model_strobes", 64'(strobe_cnt - s0), 64'(m_strobe));
    endtask

    task automatic tick();
        do_tick(1'b0, 0, '0, '0);
    endtask

    task automatic write_idle(input int unsigned a, input logic [INC_WIDTH-1:0] inc,
                              input logic [LEN_WIDTH-1:0] len);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 4'(a); wr_increment = inc; wr_gate_len = len;
        @(posedge clk); #1 wr_en = 1'b0;
        m_ram_inc[a] = inc;
        m_ram_len[a] = len;
    endtask

    task automatic stop_run();
        run = 1'b0;
        @(posedge clk); #1;
        m_play = 1'b0; m_step = 0; m_t = 0;
        chk("stop_gate", 64'(gate), 64'd0);
        chk("stop_step", 64'(step), 64'd0);
    endtask

    initial begin
        int unsigned s0;
        int unsigned f0;
        rst = 1'b1; run = 1'b1; sample_clock = 1'b0;
        tempo = 16'd8; num_steps = 5'd4;
        wr_en = 1'b0; wr_addr = '0; wr_increment = '0; wr_gate_len = '0;

        note_inc[0] = calc_increment(261626);
        note_inc[1] = calc_increment(329628);
        note_inc[2] = calc_increment(391995);
        note_inc[3] = calc_increment(523251);

        // Basic loop: tempo 8, len 4, four steps; expected after each group of ticks.
        tbl[0] = '{1, 0, 1'b1, 1, 0};
        tbl[1] = '{3, 0, 1'b1, 0, 0};
        tbl[2] = '{1, 0, 1'b0, 0, 0};
        tbl[3] = '{3, 0, 1'b0, 0, 0};
        tbl[4] = '{1, 1, 1'b1, 1, 1};
        tbl[5] = '{4, 1, 1'b0, 0, 1};
        tbl[6] = '{4, 2, 1'b1, 1, 2};
        tbl[7] = '{8, 3, 1'b1, 1, 3};
        tbl[8] = '{8, 0, 1'b1, 1, 0};
        tbl[9] = '{4, 0, 1'b0, 0, 0};

        // Reset held with run=1 and sample_clock toggling.
        for (int i = 0; i < 10; i++) begin
            repeat (5) @(posedge clk);
            sample_clock = ~sample_clock;
        end
        #1;
        chk("rst_increment", 64'(increment), 64'd0);
        chk("rst_gate", 64'(gate), 64'd0);
        chk("rst_step", 64'(step), 64'd0);
        chk("rst_strobe", 64'(step_strobe), 64'd0);
        sample_clock = 1'b0;
        run = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        s0 = strobe_cnt;
        repeat (20) tick();
        chk("idle_no_strobe", 64'(strobe_cnt - s0), 64'd0);

        for (int i = 0; i < 16; i++) begin
            write_idle(i, (i < 4) ? note_inc[i] : INC_WIDTH'($urandom), 16'd4);
        end

        run = 1'b1;
        foreach (tbl[i]) begin
            s0 = strobe_cnt;
            repeat (tbl[i].ticks) tick();
            chk("tbl_step", 64'(step), 64'(tbl[i].exp_step));
            chk("tbl_gate", 64'(gate), 64'(tbl[i].exp_gate));
            chk("tbl_strobes", 64'(strobe_cnt - s0), 64'(tbl[i].exp_strobes));
            chk("tbl_increment", 64'(increment), 64'(note_inc[tbl[i].note]));
        end

        // Rest on step 1, legato from step 2 into step 3.
        write_idle(1, note_inc[1], 16'd0);
        write_idle(2, note_inc[2], 16'd8);
        repeat (4) tick();
        chk("rest_step", 64'(step), 64'd1);
        chk("rest_increment", 64'(increment), 64'(note_inc[1]));
        chk("rest_gate0", 64'(gate), 64'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rest_gate", 64'(gate), 64'd0);
        end
        tick();
        chk("legato_start_gate", 64'(gate), 64'd1);
        f0 = gate_falls;
        repeat (10) tick();
        chk("legato_step", 64'(step), 64'd3);
        chk("legato_gate", 64'(gate), 64'd1);
        chk("legato_no_fall", 64'(gate_falls - f0), 64'd0);

        // Stop during step 2, then restart from step 0.
        repeat (6 + 8 + 8 + 2) tick();
        chk("pre_stop_step", 64'(step), 64'd2);
        stop_run();
        run = 1'b1;
        s0 = strobe_cnt;
        tick();
        chk("restart_strobe", 64'(strobe_cnt - s0), 64'd1);
        chk("restart_step", 64'(step), 64'd0);
        chk("restart_inc", 64'(increment), 64'(note_inc[0]));

        // Clamps.
        stop_run();
        tempo = '0; num_steps = 5'd4; run = 1'b1;
        s0 = strobe_cnt;
        repeat (6) tick();
        chk("tempo0_strobes", 64'(strobe_cnt - s0), 64'd6);
        chk("tempo0_step", 64'(step), 64'd1);
        stop_run();
        num_steps = 5'd0; run = 1'b1;
        repeat (5) tick();
        chk("num0_step", 64'(step), 64'd0);
        stop_run();
        num_steps = 5'd20; run = 1'b1;
        repeat (16) tick();
        chk("num20_last", 64'(step), 64'd15);
        tick();
        chk("num20_wrap", 64'(step), 64'd0);

        // Write to step 1 on the very clk that loads step 1.
        stop_run();
        num_steps = 5'd4; run = 1'b1;
        tick();
        do_tick(1'b1, 1, INC_WIDTH'(21'h0ABCDE), 16'd1);
        chk("hazard_old", 64'(increment), 64'(note_inc[1]));
        repeat (4) tick();
        chk("hazard_new_step", 64'(step), 64'd1);
        chk("hazard_new", 64'(increment), 64'h0ABCDE);

        // Randomized play.
        for (int i = 0; i < 300; i++) begin
            if ((!m_play || m_t == 0) && $urandom_range(0, 4) == 0)
                tempo = TEMPO_WIDTH'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0)
                num_steps = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 19) == 0) begin
                if (run) stop_run();
                else run = 1'b1;
            end
            if ($urandom_range(0, 2) == 0)
                do_tick(1'b1, $urandom_range(0, 15), INC_WIDTH'($urandom),
                        LEN_WIDTH'($urandom_range(0, 5)));
            else
                tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
